// File: rtl/registro_salida_rtc.sv
// PicoBlaze output port bank for the RTC: validated BCD shadow
// registers, atomic commit to the active set, edit cursor and error flag.
module registro_salida_rtc (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Port_ID,
    input  logic [7:0] Out_Port,
    input  logic       write_strobe,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic [2:0] cursor,
    output logic       actualiza,
    output logic       error
);

    typedef enum logic {IDLE, COPIA} state_t;

    state_t     state;
    logic       strobe_q;
    logic       ev;
    logic       wr_field;
    logic       wr_ctrl;
    logic       wr_cur;
    logic       field_ok;
    logic       cur_ok;
    logic       reject;
    logic       commit_req;
    logic [7:0] sh  [6];
    logic [7:0] act [6];

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    assign ev       = write_strobe & ~strobe_q;
    assign wr_field = ev && (Port_ID[7:3] == 5'b00010)
                      && (Port_ID[2:0] <= 3'd5);
    assign wr_ctrl  = ev && (Port_ID == 8'h16);
    assign wr_cur   = ev && (Port_ID == 8'h17);

    always_comb begin
        field_ok = 1'b0;
        unique case (Port_ID[2:0])
            3'd0, 3'd1: field_ok = bcd_ok(Out_Port) && (Out_Port <= 8'h59);
            3'd2:       field_ok = bcd_ok(Out_Port) && (Out_Port <= 8'h23);
            3'd3:       field_ok = bcd_ok(Out_Port) && (Out_Port >= 8'h01)
                                   && (Out_Port <= 8'h31);
            3'd4:       field_ok = bcd_ok(Out_Port) && (Out_Port >= 8'h01)
                                   && (Out_Port <= 8'h12);
            3'd5:       field_ok = bcd_ok(Out_Port);
            default:    field_ok = 1'b0;
        endcase
    end

    assign cur_ok     = (Out_Port[7:3] == 5'd0) && (Out_Port[2:0] <= 3'd5);
    assign reject     = (wr_field && !field_ok) || (wr_cur && !cur_ok);
    assign commit_req = wr_ctrl && Out_Port[0];

    // Write side: edge detector, shadow set, cursor and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q <= 1'b0;
            cursor   <= 3'd0;
            error    <= 1'b0;
            for (int i = 0; i < 6; i++)
                sh[i] <= (i == 3 || i == 4) ? 8'h01 : 8'h00;
        end else begin
            strobe_q <= write_strobe;
            if (wr_field && field_ok)
                sh[Port_ID[2:0]] <= Out_Port;
            if (wr_cur && cur_ok)
                cursor <= Out_Port[2:0];
            if (reject)
                error <= 1'b1;
            else if (wr_ctrl && Out_Port[1])
                error <= 1'b0;
        end
    end

    // Commit FSM: active set copies the shadow set in one COPIA cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            actualiza <= 1'b0;
            for (int i = 0; i < 6; i++)
                act[i] <= (i == 3 || i == 4) ? 8'h01 : 8'h00;
        end else begin
            actualiza <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (commit_req)
                        state <= COPIA;
                end
                COPIA: begin
                    for (int i = 0; i < 6; i++)
                        act[i] <= sh[i];
                    actualiza <= 1'b1;
                    state     <= commit_req ? COPIA : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign seg  = act[0];
    assign min  = act[1];
    assign hora = act[2];
    assign dia  = act[3];
    assign mes  = act[4];
    assign anio = act[5];

endmodule

// File: tb/tb_registro_salida_rtc.sv
// Randomized and directed check of registro_salida_rtc against
// a transaction-level model of the port bank.
module tb_registro_salida_rtc;

    logic       clk;
    logic       reset;
    logic [7:0] Port_ID;
    logic [7:0] Out_Port;
    logic       write_strobe;
    logic [7:0] seg, min, hora, dia, mes, anio;
    logic [2:0] cursor;
    logic       actualiza;
    logic       error;

    registro_salida_rtc dut (
        .clk(clk), .reset(reset), .Port_ID(Port_ID),
        .Out_Port(Out_Port), .write_strobe(write_strobe),
        .seg(seg), .min(min), .hora(hora), .dia(dia),
        .mes(mes), .anio(anio), .cursor(cursor),
        .actualiza(actualiza), .error(error)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, a, e, $time);
        end
    endtask

    // Model: fields as integers, commits as scheduled copy times.
    int m_sh [6];
    int m_act [6];
    int m_cur, m_err, m_pulse, m_prev, cyc;
    int q [$];

    function automatic bit ok_field(input int f, input int v);
        int hi, lo, d;
        hi = v / 16;
        lo = v % 16;
        if (hi > 9 || lo > 9) return 1'b0;
        d = hi * 10 + lo;
        case (f)
            0, 1:    return d <= 59;
            2:       return d <= 23;
            3:       return d >= 1 && d <= 31;
            4:       return d >= 1 && d <= 12;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sh  = '{0, 0, 0, 1, 1, 0};
            m_act = '{0, 0, 0, 1, 1, 0};
            m_cur = 0; m_err = 0; m_pulse = 0; m_prev = 0;
            q.delete();
        end else begin
            int a, d;
            bit ev;
            m_pulse = 0;
            while (q.size() > 0 && q[0] == cyc) begin
                void'(q.pop_front());
                m_act   = m_sh;
                m_pulse = 1;
            end
            ev     = write_strobe && !m_prev;
            m_prev = int'(write_strobe);
            if (ev) begin
                a = int'(Port_ID);
                d = int'(Out_Port);
                if (a >= 16 && a <= 21) begin
                    if (ok_field(a - 16, d)) m_sh[a - 16] = d;
                    else m_err = 1;
                end else if (a == 22) begin
                    if ((d >> 1) % 2 == 1) m_err = 0;
                    if (d % 2 == 1) q.push_back(cyc + 1);
                end else if (a == 23) begin
                    if (d <= 5) m_cur = d;
                    else m_err = 1;
                end
            end
            cyc++;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("seg", seg, m_act[0]);
        chk("min", min, m_act[1]);
        chk("hora", hora, m_act[2]);
        chk("dia", dia, m_act[3]);
        chk("mes", mes, m_act[4]);
        chk("anio", anio, m_act[5]);
        chk("cursor", cursor, m_cur);
        chk("error", error, m_err);
        chk("actualiza", actualiza, m_pulse);
    end

    always @(posedge clk) begin
        #1;
        if (actualiza === 1'b1) pulses++;
    end

    task automatic wr(input int a, input int d);
        @(negedge clk);
        Port_ID      = 8'(a);
        Out_Port     = 8'(d);
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    initial begin
        cyc = 0;
        reset = 1'b0;
        write_strobe = 1'b0;
        Port_ID = 8'h00;
        Out_Port = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 8'h00);
        chk("rst_dia", dia, 8'h01);
        chk("rst_mes", mes, 8'h01);
        chk("rst_cursor", cursor, 0);
        chk("rst_error", error, 0);
        chk("rst_act", actualiza, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        wr(8'h11, 8'h45);
        repeat (3) @(negedge clk);
        chk("min_shadow_only", min, 8'h00);
        pulses = 0;
        wr(8'h16, 8'h01);
        chk("min_copia", min, 8'h00);
        @(negedge clk);
        chk("min_commit", min, 8'h45);
        chk("act_high", actualiza, 1);
        @(negedge clk);
        chk("act_low", actualiza, 0);
        chk("one_pulse", pulses, 1);

        wr(8'h12, 8'h24);
        wr(8'h13, 8'h00);
        wr(8'h15, 8'h1A);
        wr(8'h16, 8'h01);
        repeat (2) @(negedge clk);
        chk("hora_bad", hora, 8'h00);
        chk("dia_bad", dia, 8'h01);
        chk("anio_bad", anio, 8'h00);
        chk("err_set", error, 1);
        wr(8'h16, 8'h02);
        chk("err_clr", error, 0);

        pulses = 0;
        @(negedge clk);
        Port_ID = 8'h16; Out_Port = 8'h01; write_strobe = 1'b1;
        repeat (5) @(negedge clk);
        write_strobe = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_strobe_pulses", pulses, 1);
        pulses = 0;
        wr(8'h16, 8'h01);
        wr(8'h16, 8'h01);
        repeat (6) @(negedge clk);
        chk("b2b_pulses", pulses, 2);

        wr(8'h17, 8'h03);
        chk("cursor3", cursor, 3);
        wr(8'h17, 8'h07);
        wr(8'h17, 8'h13);
        chk("cursor_kept", cursor, 3);
        chk("cursor_err", error, 1);

        wr(8'h10, 8'h30);
        wr(8'h16, 8'h01);
        pulses = 0;
        #1 reset = 1'b0;
        #1;
        chk("abort_min", min, 8'h00);
        chk("abort_seg", seg, 8'h00);
        chk("abort_act", actualiza, 0);
        @(negedge clk);
        Port_ID = 8'h17; Out_Port = 8'h04; write_strobe = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("edge_at_release", cursor, 4);
        write_strobe = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_pulse", pulses, 0);

        for (int i = 0; i < 400; i++) begin
            int sel, hold, gap;
            sel = $urandom_range(0, 9);
            @(negedge clk);
            if (sel < 8) Port_ID = 8'(8'h10 + sel);
            else if (sel == 8) Port_ID = 8'($urandom_range(0, 255));
            else Port_ID = 8'h16;
            if ($urandom_range(0, 1) == 1)
                Out_Port = 8'($urandom_range(0, 255));
            else
                Out_Port = 8'($urandom_range(0, 8'h35));
            write_strobe = 1'b1;
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(1, 2);
            repeat (hold) @(negedge clk);
            write_strobe = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
